memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Single-master CPU data-bus router placed between the CPU load/store port and three memory-mapped slaves: DTCM, GPIO and RTC.
- Decodes `cpu_addr` against three parameterised inclusive address windows and forwards the request to exactly one slave.
- Registers the selected slave's read data and ready handshake back to the CPU.
- Unmapped addresses complete with a zero read, so the CPU never hangs.

Parameters:
- IO_MAP_WIDTH, 32, width of every address and data bus.
- DTCM_BASE_ADDR, 32'h0000_0000, first DTCM address (inclusive).
- DTCM_ADDR_END, 32'h0000_0FFF, last DTCM address (inclusive).
- GPIO_BASE_ADDR, 32'h0000_1000, first GPIO address (inclusive).
- GPIO_ADDR_END, 32'h0000_1FFF, last GPIO address (inclusive).
- RTC_BASE_ADDR, 32'h0000_2000, first RTC address (inclusive).
- RTC_ADDR_END, 32'h0000_2FFF, last RTC address (inclusive).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  IO_MAP_WIDTH  CPU byte address.
- cpu_wdata  in  IO_MAP_WIDTH  CPU write data.
- cpu_rdata  out  IO_MAP_WIDTH  registered read data to the CPU.
- cpu_rw  in  1  1 = write, 0 = read.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- dtcm_addr / gpio_addr / rtc_addr  out  IO_MAP_WIDTH  forwarded address.
- dtcm_wdata / gpio_wdata / rtc_wdata  out  IO_MAP_WIDTH  forwarded write data.
- dtcm_rdata / gpio_rdata / rtc_rdata  in  IO_MAP_WIDTH  slave read data.
- dtcm_rw / gpio_we / rtc_we  out  1  write strobe, asserted only for the selected slave.
- dtcm_ready / gpio_ready / rtc_ready  in  1  slave completion.

Behaviour:
- Decode is combinational: sel_x = (cpu_addr >= X_BASE) && (cpu_addr <= X_END), using unsigned compare.
  - If parameter windows overlap, priority is DTCM > GPIO > RTC, so at most one select is active.
  - No select active means the access is unmapped.
- Request routing is combinational and has zero latency.
  - Selected slave: addr = {cpu_addr[W-1:2], 2'b00} (word-aligned), wdata = cpu_wdata, write strobe = cpu_rw.
  - Unselected slaves: addr = 0, wdata = 0, write strobe = 0.
- Response is registered, with 1-cycle latency from the slave's ready.
  - On each clk edge, if the selected slave's ready = 1: cpu_ready <= 1.
    - For a read: cpu_rdata <= that slave's rdata.
    - For a write: cpu_rdata holds its previous value.
  - Unmapped access: cpu_ready <= 1 and cpu_rdata <= 0 on every edge while the address stays unmapped. Writes to unmapped space are discarded.
  - Otherwise cpu_ready <= 0. cpu_ready is high for exactly one cycle per slave ready cycle; a slave holding ready for N cycles yields N pulses.
- Ready or rdata from an unselected slave is ignored, even if it arrives in the same cycle as the selected slave's ready.
- Address change mid-transaction: routing follows the new address immediately; a pending ready from the old slave is ignored.
- Reset (asynchronous, any time, including mid-transaction): cpu_ready = 0, cpu_rdata = 0; any in-flight response is dropped.
  - Slave-side outputs remain combinational and reflect the CPU inputs during reset.
- Window boundaries: BASE and END are both inclusive. 0x0FFC and 0x0FFF select DTCM; 0x1000 selects GPIO; 0x3000 is unmapped.
- No internal FSM beyond the two response registers. No buffering; the CPU holds its request until cpu_ready.

Decomposition:
- Shared package `soc_map_pkg`: default base/end constants for each region, IO_MAP_WIDTH, and a one-hot select enum/typedef {SEL_NONE, SEL_DTCM, SEL_GPIO, SEL_RTC}.
- One sub-module, `addr_decoder`: address and window parameters in, one-hot select out, priority encoding included.
- Routing muxes and response registers stay in memory_arbiter.

Test Plan:
- Reset: rst = 1 for 2 cycles -> cpu_ready = 0, cpu_rdata = 0; release -> both stay 0 with no slave ready.
- DTCM write then read:
  - addr 0x0000_0000, wdata 0xDEADBEEF, rw = 1, dtcm_ready pulse -> dtcm_rw = 1, dtcm_wdata = 0xDEADBEEF, gpio_we = rtc_we = 0, cpu_ready high one cycle later.
  - Read with dtcm_rdata = 0xDEADBEEF -> cpu_rdata = 0xDEADBEEF with cpu_ready.
- GPIO at 0x0000_1000:
  - Write 0x12345678 -> only gpio_we = 1.
  - Read with gpio_rdata = 0x12345678 -> cpu_rdata = 0x12345678; dtcm_ready toggled during the access is ignored.
- RTC at 0x0000_2000: write 0x87654321 -> only rtc_we = 1; read returns 0x87654321 one cycle after rtc_ready.
- Boundaries:
  - Read 0x0000_0FFC with dtcm_rdata = 0xAABBCCDD -> DTCM selected, cpu_rdata = 0xAABBCCDD.
  - 0x0000_1FFF selects GPIO; 0x0000_0FFE forwards dtcm_addr = 0x0000_0FFC.
- Unmapped and mid-operation reset:
  - Read 0x0000_3000 -> no slave strobe, cpu_ready = 1 next cycle, cpu_rdata = 0.
  - Assert rst in the cycle dtcm_ready = 1 -> no cpu_ready pulse.

Source files
------------

// File: rtl/soc_map_pkg.sv
// rtl/soc_map_pkg.sv - shared SoC memory map constants and slave select type
package soc_map_pkg;

   localparam int unsigned IO_MAP_WIDTH = 32;

   localparam logic [31:0] DTCM_BASE_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] DTCM_END_DEFAULT  = 32'h0000_0FFF;
   localparam logic [31:0] GPIO_BASE_DEFAULT = 32'h0000_1000;
   localparam logic [31:0] GPIO_END_DEFAULT  = 32'h0000_1FFF;
   localparam logic [31:0] RTC_BASE_DEFAULT  = 32'h0000_2000;
   localparam logic [31:0] RTC_END_DEFAULT   = 32'h0000_2FFF;

   // One-hot slave select; SEL_NONE marks an unmapped access
   typedef enum logic [2:0] {
      SEL_NONE = 3'b000,
      SEL_DTCM = 3'b001,
      SEL_GPIO = 3'b010,
      SEL_RTC  = 3'b100
   } sel_t;

endpackage

// File: rtl/addr_decoder.sv
// rtl/addr_decoder.sv - priority window decoder producing a one-hot slave select
module addr_decoder
   import soc_map_pkg::*;
#(
   parameter int unsigned             ADDR_W    = IO_MAP_WIDTH,
   parameter logic [ADDR_W-1:0]       DTCM_BASE = DTCM_BASE_DEFAULT,
   parameter logic [ADDR_W-1:0]       DTCM_END  = DTCM_END_DEFAULT,
   parameter logic [ADDR_W-1:0]       GPIO_BASE = GPIO_BASE_DEFAULT,
   parameter logic [ADDR_W-1:0]       GPIO_END  = GPIO_END_DEFAULT,
   parameter logic [ADDR_W-1:0]       RTC_BASE  = RTC_BASE_DEFAULT,
   parameter logic [ADDR_W-1:0]       RTC_END   = RTC_END_DEFAULT
) (
   input  logic [ADDR_W-1:0] addr_i,
   output sel_t              sel_o
);

   // Inclusive window test written as an offset compare: addresses below BASE
   // wrap to a huge offset and fall outside, and a zero BASE needs no
   // always-true compare.
   localparam logic [ADDR_W-1:0] DTCM_SPAN = DTCM_END - DTCM_BASE;
   localparam logic [ADDR_W-1:0] GPIO_SPAN = GPIO_END - GPIO_BASE;
   localparam logic [ADDR_W-1:0] RTC_SPAN  = RTC_END - RTC_BASE;

   logic [ADDR_W-1:0] dtcm_off;
   logic [ADDR_W-1:0] gpio_off;
   logic [ADDR_W-1:0] rtc_off;
   logic              in_dtcm;
   logic              in_gpio;
   logic              in_rtc;

   assign dtcm_off = addr_i - DTCM_BASE;
   assign gpio_off = addr_i - GPIO_BASE;
   assign rtc_off  = addr_i - RTC_BASE;

   assign in_dtcm = (dtcm_off <= DTCM_SPAN);
   assign in_gpio = (gpio_off <= GPIO_SPAN);
   assign in_rtc  = (rtc_off <= RTC_SPAN);

   // Priority DTCM > GPIO > RTC so overlapping windows still yield one select
   always_comb begin
      sel_o = SEL_NONE;
      if (in_rtc)  sel_o = SEL_RTC;
      if (in_gpio) sel_o = SEL_GPIO;
      if (in_dtcm) sel_o = SEL_DTCM;
   end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - CPU data-bus router to DTCM, GPIO and RTC slaves
module memory_arbiter #(
   parameter int unsigned                   IO_MAP_WIDTH   = soc_map_pkg::IO_MAP_WIDTH,
   parameter logic [IO_MAP_WIDTH-1:0]       DTCM_BASE_ADDR = soc_map_pkg::DTCM_BASE_DEFAULT,
   parameter logic [IO_MAP_WIDTH-1:0]       DTCM_ADDR_END  = soc_map_pkg::DTCM_END_DEFAULT,
   parameter logic [IO_MAP_WIDTH-1:0]       GPIO_BASE_ADDR = soc_map_pkg::GPIO_BASE_DEFAULT,
   parameter logic [IO_MAP_WIDTH-1:0]       GPIO_ADDR_END  = soc_map_pkg::GPIO_END_DEFAULT,
   parameter logic [IO_MAP_WIDTH-1:0]       RTC_BASE_ADDR  = soc_map_pkg::RTC_BASE_DEFAULT,
   parameter logic [IO_MAP_WIDTH-1:0]       RTC_ADDR_END   = soc_map_pkg::RTC_END_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IO_MAP_WIDTH-1:0] cpu_addr,
   input  logic [IO_MAP_WIDTH-1:0] cpu_wdata,
   output logic [IO_MAP_WIDTH-1:0] cpu_rdata,
   input  logic                    cpu_rw,
   output logic                    cpu_ready,
   output logic [IO_MAP_WIDTH-1:0] dtcm_addr,
   output logic [IO_MAP_WIDTH-1:0] dtcm_wdata,
   input  logic [IO_MAP_WIDTH-1:0] dtcm_rdata,
   output logic                    dtcm_rw,
   input  logic                    dtcm_ready,
   output logic [IO_MAP_WIDTH-1:0] gpio_addr,
   output logic [IO_MAP_WIDTH-1:0] gpio_wdata,
   input  logic [IO_MAP_WIDTH-1:0] gpio_rdata,
   output logic                    gpio_we,
   input  logic                    gpio_ready,
   output logic [IO_MAP_WIDTH-1:0] rtc_addr,
   output logic [IO_MAP_WIDTH-1:0] rtc_wdata,
   input  logic [IO_MAP_WIDTH-1:0] rtc_rdata,
   output logic                    rtc_we,
   input  logic                    rtc_ready
);

   import soc_map_pkg::*;

   sel_t                    sel;
   logic [IO_MAP_WIDTH-1:0] word_addr;
   logic                    resp_ready;
   logic [IO_MAP_WIDTH-1:0] resp_rdata;
   logic                    ready_d;
   logic                    ready_q;
   logic [IO_MAP_WIDTH-1:0] rdata_d;
   logic [IO_MAP_WIDTH-1:0] rdata_q;

   addr_decoder #(
      .ADDR_W    (IO_MAP_WIDTH),
      .DTCM_BASE (DTCM_BASE_ADDR),
      .DTCM_END  (DTCM_ADDR_END),
      .GPIO_BASE (GPIO_BASE_ADDR),
      .GPIO_END  (GPIO_ADDR_END),
      .RTC_BASE  (RTC_BASE_ADDR),
      .RTC_END   (RTC_ADDR_END)
   ) u_addr_decoder (
      .addr_i (cpu_addr),
      .sel_o  (sel)
   );

   assign word_addr = {cpu_addr[IO_MAP_WIDTH-1:2], 2'b00};

   // Zero-latency request routing; unselected slaves see an idle, all-zero bus
   always_comb begin
      dtcm_addr  = '0;
      dtcm_wdata = '0;
      dtcm_rw    = 1'b0;
      gpio_addr  = '0;
      gpio_wdata = '0;
      gpio_we    = 1'b0;
      rtc_addr   = '0;
      rtc_wdata  = '0;
      rtc_we     = 1'b0;
      case (sel)
         SEL_DTCM: begin
            dtcm_addr  = word_addr;
            dtcm_wdata = cpu_wdata;
            dtcm_rw    = cpu_rw;
         end
         SEL_GPIO: begin
            gpio_addr  = word_addr;
            gpio_wdata = cpu_wdata;
            gpio_we    = cpu_rw;
         end
         SEL_RTC: begin
            rtc_addr  = word_addr;
            rtc_wdata = cpu_wdata;
            rtc_we    = cpu_rw;
         end
         default: ;
      endcase
   end

   // Pick the selected slave's response; unmapped space answers at once with zero
   always_comb begin
      resp_ready = 1'b1;
      resp_rdata = '0;
      case (sel)
         SEL_DTCM: begin
            resp_ready = dtcm_ready;
            resp_rdata = dtcm_rdata;
         end
         SEL_GPIO: begin
            resp_ready = gpio_ready;
            resp_rdata = gpio_rdata;
         end
         SEL_RTC: begin
            resp_ready = rtc_ready;
            resp_rdata = rtc_rdata;
         end
         default: ;
      endcase
   end

   // Next response state: reads capture data, mapped writes keep the last read
   always_comb begin
      ready_d = resp_ready;
      rdata_d = rdata_q;
      if (resp_ready && (!cpu_rw || (sel == SEL_NONE))) begin
         rdata_d = resp_rdata;
      end
   end

   // Response registers; reset drops any in-flight completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end
   end

   assign cpu_ready = ready_q;
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - table-driven self-checking bench for memory_arbiter
module tb_memory_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_rw;
   logic        cpu_ready;
   logic [31:0] dtcm_addr;
   logic [31:0] dtcm_wdata;
   logic [31:0] dtcm_rdata;
   logic        dtcm_rw;
   logic        dtcm_ready;
   logic [31:0] gpio_addr;
   logic [31:0] gpio_wdata;
   logic [31:0] gpio_rdata;
   logic        gpio_we;
   logic        gpio_ready;
   logic [31:0] rtc_addr;
   logic [31:0] rtc_wdata;
   logic [31:0] rtc_rdata;
   logic        rtc_we;
   logic        rtc_ready;

   int errors;
   int checks;

   memory_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_rw     (cpu_rw),
      .cpu_ready  (cpu_ready),
      .dtcm_addr  (dtcm_addr),
      .dtcm_wdata (dtcm_wdata),
      .dtcm_rdata (dtcm_rdata),
      .dtcm_rw    (dtcm_rw),
      .dtcm_ready (dtcm_ready),
      .gpio_addr  (gpio_addr),
      .gpio_wdata (gpio_wdata),
      .gpio_rdata (gpio_rdata),
      .gpio_we    (gpio_we),
      .gpio_ready (gpio_ready),
      .rtc_addr   (rtc_addr),
      .rtc_wdata  (rtc_wdata),
      .rtc_rdata  (rtc_rdata),
      .rtc_we     (rtc_we),
      .rtc_ready  (rtc_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // rdy and exp_sel bit order: {rtc, gpio, dtcm}
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rw;
      logic [31:0] d_rd;
      logic [31:0] g_rd;
      logic [31:0] r_rd;
      logic [2:0]  rdy;
      logic [2:0]  exp_sel;
      logic [31:0] exp_fa;
      logic        exp_ready;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rw,
                        input logic [31:0] drd, input logic [31:0] grd, input logic [31:0] rrd,
                        input logic [2:0] rdy);
      cpu_addr   = a;
      cpu_wdata  = wd;
      cpu_rw     = rw;
      dtcm_rdata = drd;
      gpio_rdata = grd;
      rtc_rdata  = rrd;
      dtcm_ready = rdy[0];
      gpio_ready = rdy[1];
      rtc_ready  = rdy[2];
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);

      // Reset held two cycles, then released with no slave ready
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {31'd0, cpu_ready}, 32'h0);
      check("reset_rdata", cpu_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_ready", {31'd0, cpu_ready}, 32'h0);
      check("idle_rdata", cpu_rdata, 32'h0);

      //            addr          wdata         rw    dtcm_rd       gpio_rd       rtc_rd        rdy     sel     fwd addr      rdy   rdata
      vq.push_back('{32'h0000_0000, 32'hDEADBEEF, 1'b1, 32'h0,        32'h0,        32'h0,        3'b001, 3'b001, 32'h0000_0000, 1'b1, 32'h0000_0000});
      vq.push_back('{32'h0000_0000, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        32'h0,        3'b001, 3'b001, 32'h0000_0000, 1'b1, 32'hDEADBEEF});
      vq.push_back('{32'h0000_1000, 32'h12345678, 1'b1, 32'h0,        32'h0,        32'h0,        3'b010, 3'b010, 32'h0000_1000, 1'b1, 32'hDEADBEEF});
      vq.push_back('{32'h0000_1000, 32'h0,        1'b0, 32'h00000BAD, 32'h12345678, 32'h0,        3'b011, 3'b010, 32'h0000_1000, 1'b1, 32'h12345678});
      vq.push_back('{32'h0000_1000, 32'h0,        1'b0, 32'h00000BAD, 32'h12345678, 32'h0,        3'b001, 3'b010, 32'h0000_1000, 1'b0, 32'h12345678});
      vq.push_back('{32'h0000_2000, 32'h87654321, 1'b1, 32'h0,        32'h0,        32'h0,        3'b100, 3'b100, 32'h0000_2000, 1'b1, 32'h12345678});
      vq.push_back('{32'h0000_2000, 32'h0,        1'b0, 32'h0,        32'h0,        32'h87654321, 3'b000, 3'b100, 32'h0000_2000, 1'b0, 32'h12345678});
      vq.push_back('{32'h0000_2000, 32'h0,        1'b0, 32'h0,        32'h0,        32'h87654321, 3'b100, 3'b100, 32'h0000_2000, 1'b1, 32'h87654321});
      vq.push_back('{32'h0000_0FFC, 32'h0,        1'b0, 32'hAABBCCDD, 32'h0,        32'h0,        3'b001, 3'b001, 32'h0000_0FFC, 1'b1, 32'hAABBCCDD});
      vq.push_back('{32'h0000_1FFF, 32'h0,        1'b0, 32'h0,        32'h00000055, 32'h0,        3'b010, 3'b010, 32'h0000_1FFC, 1'b1, 32'h00000055});
      vq.push_back('{32'h0000_0FFE, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        3'b000, 3'b001, 32'h0000_0FFC, 1'b0, 32'h00000055});
      vq.push_back('{32'h0000_3000, 32'h0,        1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 3'b111, 3'b000, 32'h0000_0000, 1'b1, 32'h00000000});
      vq.push_back('{32'h0000_3000, 32'h5A5A5A5A, 1'b1, 32'h0,        32'h0,        32'h0,        3'b000, 3'b000, 32'h0000_0000, 1'b1, 32'h00000000});
      vq.push_back('{32'h0000_2FFF, 32'h0,        1'b0, 32'h0,        32'h0,        32'h11112222, 3'b100, 3'b100, 32'h0000_2FFC, 1'b1, 32'h11112222});
      vq.push_back('{32'h0000_0FFF, 32'hCAFEF00D, 1'b1, 32'h0,        32'h0,        32'h0,        3'b001, 3'b001, 32'h0000_0FFC, 1'b1, 32'h11112222});

      foreach (vq[i]) begin
         vec_t v;
         logic [2:0] exp_we;
         v = vq[i];
         exp_we = v.exp_sel & {3{v.rw}};
         @(negedge clk);
         drive(v.addr, v.wdata, v.rw, v.d_rd, v.g_rd, v.r_rd, v.rdy);
         #1;
         check($sformatf("v%0d_strobes", i), {29'd0, rtc_we, gpio_we, dtcm_rw}, {29'd0, exp_we});
         check($sformatf("v%0d_dtcm_addr", i), dtcm_addr, v.exp_sel[0] ? v.exp_fa : 32'h0);
         check($sformatf("v%0d_gpio_addr", i), gpio_addr, v.exp_sel[1] ? v.exp_fa : 32'h0);
         check($sformatf("v%0d_rtc_addr", i), rtc_addr, v.exp_sel[2] ? v.exp_fa : 32'h0);
         check($sformatf("v%0d_dtcm_wdata", i), dtcm_wdata, v.exp_sel[0] ? v.wdata : 32'h0);
         check($sformatf("v%0d_gpio_wdata", i), gpio_wdata, v.exp_sel[1] ? v.wdata : 32'h0);
         check($sformatf("v%0d_rtc_wdata", i), rtc_wdata, v.exp_sel[2] ? v.wdata : 32'h0);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_cpu_ready", i), {31'd0, cpu_ready}, {31'd0, v.exp_ready});
         check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, v.exp_rdata);
      end

      // Reset asserted in the same cycle as dtcm_ready: no pulse, data cleared,
      // slave side still follows the CPU inputs
      @(negedge clk);
      drive(32'h0000_0010, 32'h0BADF00D, 1'b1, 32'h00000099, 32'h0, 32'h0, 3'b001);
      rst = 1'b1;
      #1;
      check("rst_dtcm_rw", {31'd0, dtcm_rw}, 32'h1);
      check("rst_dtcm_addr", dtcm_addr, 32'h0000_0010);
      check("rst_dtcm_wdata", dtcm_wdata, 32'h0BADF00D);
      @(posedge clk);
      #1;
      check("rst_mid_ready", {31'd0, cpu_ready}, 32'h0);
      check("rst_mid_rdata", cpu_rdata, 32'h0);

      // Asynchronous clear of a completed response without a clock edge
      @(negedge clk);
      rst = 1'b0;
      drive(32'h0000_0004, 32'h0, 1'b0, 32'h00000077, 32'h0, 32'h0, 3'b001);
      @(posedge clk);
      #1;
      check("pre_async_ready", {31'd0, cpu_ready}, 32'h1);
      check("pre_async_rdata", cpu_rdata, 32'h00000077);
      #2;
      rst = 1'b1;
      #1;
      check("async_ready", {31'd0, cpu_ready}, 32'h0);
      check("async_rdata", cpu_rdata, 32'h0);
      @(negedge clk);
      drive(32'h0000_0004, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", {31'd0, cpu_ready}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
